deterministic_updater_n: RTL and testbench
==========================================

# deterministic_updater_n

Parametrised, multi-channel successor of the two-lane deterministic updater. It holds `N` unsigned weights and, on `start`, computes each lane's product `x_i*delta_i` with deterministic unary bitstreams, then adds it to or subtracts it from the lane weight with saturation. The block sits between the error/activation producers and the weight store of the update datapath. The exact/approximate trade-off is selected at elaboration time.

## Interface
- `N`, default 2: number of lanes.
- `W`, default 8: operand and weight width; values are unsigned fractions of 2^W.
- `MODE`, default 0: 0 = clock-division (exact, L = 2^(2W) cycles); 1 = bit-reversed single period (approximate, L = 2^W cycles).
- `clk  in  1`: clock; all state updates on the rising edge.
- `rst  in  1`: asynchronous, active-low reset.
- `start  in  1`: request an update; accepted only in IDLE.
- `x  in  N*W`: lane operand x_i at `[i*W +: W]`.
- `delta  in  N*W`: lane operand delta_i at `[i*W +: W]`.
- `dir  in  N`: per lane, 0 = add product, 1 = subtract product.
- `w_load  in  1`: load `w_in` into the weights; accepted only in IDLE.
- `w_in  in  N*W`: weight load data.
- `w_out  out  N*W`: current weights.
- `busy  out  1`: high while an update is in progress.
- `done  out  1`: one-cycle pulse when the new weights become visible.

## Operation
- States: IDLE, RUN, APPLY.
  - IDLE → RUN on `start`.
  - RUN → APPLY when the stream counter reaches L-1.
  - APPLY → IDLE unconditionally.
- On start acceptance:
  - Latch `x`, `delta` and `dir`.
  - Clear the stream counter `c` (2W bits in MODE 0, W bits in MODE 1) and the per-lane ones counters (2W bits).
  - Later changes to `x`, `delta` or `dir` have no effect on the update in progress.
- MODE 0: with `lo = c[W-1:0]` and `hi = c[2W-1:W]`, lane bit = `(lo < x_i) & (hi < delta_i)`. The ones count equals `x_i*delta_i` exactly, and `p_i = count >> W`.
- MODE 1: lane bit = `(c < x_i) & (bitrev_W(c) < delta_i)`, and `p_i = count` (W-bit, already scaled).
- Each RUN cycle adds the lane bit to that lane's ones counter.
- APPLY:
  - `w_i <= sat(w_i + p_i)` when `dir_i = 0`, clamped to 2^W-1.
  - `w_i <= sat(w_i - p_i)` when `dir_i = 1`, clamped to 0.
  - Use a W+1-bit intermediate.
- `start` or `w_load` outside IDLE is ignored, not queued.
- `w_load` and `start` in the same IDLE cycle: both are accepted; the update applies to the freshly loaded weights.
- x = 0 or delta = 0: the full L cycles still run; the weight is unchanged; `done` still pulses.
- Reset:
  - `w_out` = 0, `busy` = 0, `done` = 0, state IDLE, all counters 0.
  - Reset mid-RUN or mid-APPLY aborts with no weight write.

## Timing
- Let edge 0 be the edge that samples `start`.
- After edge 0: `busy` = 1 and state is RUN.
- Edges 1..L: each samples one stream bit; edge L moves the state to APPLY.
- Edge L+1 (APPLY): `w_out` updates, `done` = 1 for exactly one cycle, `busy` = 0, state is IDLE.
- Start-to-done latency is L+1 edges. The earliest next `start` is sampled at edge L+2.
- `w_load` takes effect on the sampling edge; `w_out` is valid the following cycle.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Package `deterministic_updater_pkg` holds:
  - the state enum (IDLE, RUN, APPLY);
  - the mode constants `MODE_CLKDIV` = 0 and `MODE_BITREV` = 1;
  - a `bitrev` function.
- Sub-module `du_lane`, instantiated N times, contains:
  - the stream comparators;
  - the AND gate and ones counter;
  - the product scaling;
  - the saturating apply logic;
  - the weight register.
- The top level owns the FSM, the shared stream counter and the input latches.

## Test plan
- Reset, then N=2, W=8, MODE=0, weights loaded to 100/100, x=25/43, delta=50/25, dir=00, start → `done` at edge 65537, `w_out` = 104/104 (products 4 and 4).
- Same operands with dir=11 → `w_out` = 96/96.
- Saturation: w=250, x=255, delta=255, dir=0 → 255. Then w=3, dir=1 → 0.
- W=4, MODE=1, x=8, delta=8, w=0 → `done` at edge 17, `w_out` = 4. Check `busy` spans edges 0..L and a `start` pulse mid-RUN is ignored.
- Loading and sequencing:
  - `w_load` (w_in=10) and `start` in the same cycle with x=16, delta=16 (W=8, MODE=0) → 11.
  - `w_load` during RUN → ignored.
  - Operand change during RUN → result unaffected.
- Deassert `rst` halfway through RUN → all outputs 0 immediately. A subsequent `start` runs the full L+1 cycles cleanly.

Source files
------------

// File: rtl/deterministic_updater_pkg.sv
// Shared types and helpers for the deterministic unary-stream weight updater.
// Holds the FSM state type, the stream-mode selectors and the bit-reversal helper.
package deterministic_updater_pkg;

   typedef enum logic [1:0] {IDLE, RUN, APPLY} state_t;

   localparam int MODE_CLKDIV = 0;
   localparam int MODE_BITREV = 1;

   // Reverses the low w bits of v; the bits above w come back as zero.
   function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < w; i++) r[i] = v[w-1-i];
      return r;
   endfunction

endpackage

// File: rtl/deterministic_updater_n_lane.sv
// One update lane: it compares the stream against the operands, counts the ones,
// then adds or subtracts the scaled product from its weight with saturation.
module du_lane
   import deterministic_updater_pkg::*;
#(
   parameter int W    = 8,
   parameter int MODE = MODE_CLKDIV,
   parameter int CW   = 2*W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          run,
   input  logic          apply,
   input  logic          load,
   input  logic [CW-1:0] c,
   input  logic [W-1:0]  x,
   input  logic [W-1:0]  delta,
   input  logic          dir,
   input  logic [W-1:0]  w_in,
   output logic [W-1:0]  w
);

   logic [W-1:0]   hi;
   logic [W-1:0]   p;
   logic [2*W-1:0] ones;
   logic [W:0]     sum;
   logic [W:0]     dif;
   logic           s;

   if (MODE == MODE_BITREV) begin : g_rev
      assign hi = W'(bitrev(32'(c), W));
      // A full single-period count already sits at weight scale.
      assign p  = (|ones[2*W-1:W]) ? '1 : ones[W-1:0];
   end else begin : g_div
      assign hi = c[CW-1:W];
      assign p  = ones[2*W-1:W];
      logic unused_lo;
      assign unused_lo = ^ones[W-1:0];
   end

   assign s   = (c[W-1:0] < x) & (hi < delta);
   assign sum = {1'b0, w} + {1'b0, p};
   assign dif = {1'b0, w} - {1'b0, p};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ones <= '0;
         w    <= '0;
      end else begin
         if (clr)      ones <= '0;
         else if (run) ones <= ones + {{(2*W-1){1'b0}}, s};
         if (load)       w <= w_in;
         else if (apply) w <= dir ? (dif[W] ? '0 : dif[W-1:0])
                                  : (sum[W] ? '1 : sum[W-1:0]);
      end
   end

endmodule

// File: rtl/deterministic_updater_n.sv
// N-lane deterministic unary-stream weight updater: the FSM, the shared stream
// counter and the operand latches, with one du_lane per weight.
module deterministic_updater_n
   import deterministic_updater_pkg::*;
#(
   parameter int N    = 2,
   parameter int W    = 8,
   parameter int MODE = MODE_CLKDIV
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N*W-1:0] x,
   input  logic [N*W-1:0] delta,
   input  logic [N-1:0] dir,
   input  logic         w_load,
   input  logic [N*W-1:0] w_in,
   output logic [N*W-1:0] w_out,
   output logic         busy,
   output logic         done
);

   localparam int CW = (MODE == MODE_BITREV) ? W : 2*W;

   state_t                  state, state_n;
   logic [CW-1:0]           c;
   logic [N-1:0][W-1:0]     x_q, d_q, w_q, wi;
   logic [N-1:0]            dir_q;
   logic                    acc, ld;

   assign acc   = (state == IDLE) & start;
   assign ld    = (state == IDLE) & w_load;
   assign wi    = w_in;
   assign w_out = w_q;

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = RUN;
         RUN:     if (&c)    state_n = APPLY;
         APPLY:   state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Operands are frozen at acceptance so the inputs may move during RUN.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         c     <= '0;
         x_q   <= '0;
         d_q   <= '0;
         dir_q <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_n;
         busy  <= (state_n != IDLE);
         done  <= (state == APPLY);
         if (acc) begin
            c     <= '0;
            x_q   <= x;
            d_q   <= delta;
            dir_q <= dir;
         end else if (state == RUN) begin
            c <= c + 1'b1;
         end
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_lane
      du_lane #(.W(W), .MODE(MODE), .CW(CW)) u_lane (
         .clk   (clk),
         .rst   (rst),
         .clr   (acc),
         .run   (state == RUN),
         .apply (state == APPLY),
         .load  (ld),
         .c     (c),
         .x     (x_q[i]),
         .delta (d_q[i]),
         .dir   (dir_q[i]),
         .w_in  (wi[i]),
         .w     (w_q[i])
      );
   end

endmodule

// File: tb/tb_deterministic_updater_n.sv
// Directed bench for deterministic_updater_n: one exact W=8 run, several W=4
// clock-division runs and a W=4 bit-reversed instance.
module tb_deterministic_updater_n;

   localparam int L8 = 65536;
   localparam int L4 = 256;
   localparam int LB = 16;

   logic clk, rst;

   logic        s8, wl8, busy8, done8;
   logic [15:0] x8, d8, wi8, wo8;
   logic [1:0]  dir8;

   logic        s4, wl4, busy4, done4;
   logic [7:0]  x4, d4, wi4, wo4;
   logic [1:0]  dir4;

   logic        sb, wlb, busyb, doneb;
   logic [3:0]  xb, db, wib, wob;
   logic [0:0]  dirb;

   int n_chk = 0;
   int n_fail = 0;
   int edges;
   bit bok;

   deterministic_updater_n #(.N(2), .W(8), .MODE(0)) dut8 (
      .clk(clk), .rst(rst), .start(s8), .x(x8), .delta(d8), .dir(dir8),
      .w_load(wl8), .w_in(wi8), .w_out(wo8), .busy(busy8), .done(done8));

   deterministic_updater_n #(.N(2), .W(4), .MODE(0)) dut4 (
      .clk(clk), .rst(rst), .start(s4), .x(x4), .delta(d4), .dir(dir4),
      .w_load(wl4), .w_in(wi4), .w_out(wo4), .busy(busy4), .done(done4));

   deterministic_updater_n #(.N(1), .W(4), .MODE(1)) dutb (
      .clk(clk), .rst(rst), .start(sb), .x(xb), .delta(db), .dir(dirb),
      .w_load(wlb), .w_in(wib), .w_out(wob), .busy(busyb), .done(doneb));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Caller raises s8 at a negedge; this covers edge 0 through the done pulse.
   task automatic run8(output int e, output bit ok);
      e = -1; ok = 1;
      @(posedge clk); #1 check("d8 e0 busy", busy8, 1);
      @(negedge clk); s8 = 0; wl8 = 0;
      for (int k = 1; k <= L8 + 4; k++) begin
         @(posedge clk); #1;
         if (done8) begin e = k; break; end
         if (!busy8) ok = 0;
      end
      @(posedge clk); #1 check("d8 done pulse", done8, 0);
   endtask

   // act 1: w_load, operand change and start during RUN; act 2: reset mid-RUN.
   task automatic run4(input int act, output int e, output bit ok);
      e = -1; ok = 1;
      @(posedge clk); #1 check("d4 e0 busy", busy4, 1);
      @(negedge clk); s4 = 0; wl4 = 0;
      for (int k = 1; k <= L4 + 4; k++) begin
         @(posedge clk); #1;
         if (act == 2 && k == 128) begin
            rst = 0; #1;
            check("rst wout", wo4, 0);
            check("rst busy", busy4, 0);
            check("rst done", done4, 0);
            return;
         end
         if (done4) begin e = k; break; end
         if (!busy4) ok = 0;
         if (act == 1 && k == 100) begin
            wl4 = 1; wi4 = '0; x4 = '1; d4 = '1; dir4 = '1; s4 = 1;
         end
         if (act == 1 && k == 101) begin wl4 = 0; s4 = 0; end
      end
      @(posedge clk); #1;
      check("d4 done pulse", done4, 0);
      check("d4 idle after", busy4, 0);
   endtask

   task automatic runb(input int act, output int e, output bit ok);
      e = -1; ok = 1;
      @(posedge clk); #1 check("db e0 busy", busyb, 1);
      @(negedge clk); sb = 0; wlb = 0;
      for (int k = 1; k <= LB + 4; k++) begin
         @(posedge clk); #1;
         if (doneb) begin e = k; break; end
         if (!busyb) ok = 0;
         if (act == 1 && k == 8) sb = 1;
         if (act == 1 && k == 9) sb = 0;
      end
      @(posedge clk); #1;
      check("db done pulse", doneb, 0);
      check("db idle after", busyb, 0);
   endtask

   initial begin
      rst = 1;
      {s8, wl8, x8, d8, dir8, wi8} = '0;
      {s4, wl4, x4, d4, dir4, wi4} = '0;
      {sb, wlb, xb, db, dirb, wib} = '0;
      #3 rst = 0;
      repeat (3) @(posedge clk);
      #1;
      check("reset wo8", wo8, 0);
      check("reset busy8", busy8, 0);
      check("reset done8", done8, 0);
      check("reset wo4", wo4, 0);
      check("reset wob", wob, 0);
      @(negedge clk) rst = 1;

      // W=8 exact: 25*50>>8 = 4, 43*25>>8 = 4
      @(negedge clk); wl8 = 1; wi8 = {8'd100, 8'd100};
      @(negedge clk); wl8 = 0;
      check("d8 load", wo8, {8'd100, 8'd100});
      x8 = {8'd43, 8'd25}; d8 = {8'd25, 8'd50}; dir8 = 2'b00; s8 = 1;
      run8(edges, bok);
      check("d8 latency", edges, L8 + 1);
      check("d8 busy span", bok, 1);
      check("d8 add", wo8, {8'd104, 8'd104});

      // W=4 add: 5*6>>4 = 1, 7*9>>4 = 3
      @(negedge clk); wl4 = 1; wi4 = {4'd10, 4'd10};
      x4 = {4'd7, 4'd5}; d4 = {4'd9, 4'd6}; dir4 = 2'b00; s4 = 1;
      run4(0, edges, bok);
      check("d4 latency", edges, L4 + 1);
      check("d4 busy span", bok, 1);
      check("d4 add", wo4, {4'd13, 4'd11});

      @(negedge clk); wl4 = 1; wi4 = {4'd10, 4'd10}; dir4 = 2'b11; s4 = 1;
      run4(0, edges, bok);
      check("d4 sub", wo4, {4'd7, 4'd9});

      // 15*15>>4 = 14: 14+14 clamps high, 3-14 clamps low
      @(negedge clk); wl4 = 1; wi4 = {4'd3, 4'd14};
      x4 = {4'd15, 4'd15}; d4 = {4'd15, 4'd15}; dir4 = 2'b10; s4 = 1;
      run4(0, edges, bok);
      check("d4 sat", wo4, {4'd0, 4'd15});

      // load and start together: 4*4>>4 = 1 added, 8*8>>4 = 4 subtracted
      @(negedge clk); wl4 = 1; wi4 = {4'd5, 4'd10};
      x4 = {4'd8, 4'd4}; d4 = {4'd8, 4'd4}; dir4 = 2'b10; s4 = 1;
      run4(0, edges, bok);
      check("d4 load+start", wo4, {4'd1, 4'd11});

      // interference during RUN: 8*8>>4 = 4, 12*4>>4 = 3
      @(negedge clk); wl4 = 1; wi4 = {4'd8, 4'd8};
      x4 = {4'd12, 4'd8}; d4 = {4'd4, 4'd8}; dir4 = 2'b00; s4 = 1;
      run4(1, edges, bok);
      check("d4 intf latency", edges, L4 + 1);
      check("d4 intf busy", bok, 1);
      check("d4 intf result", wo4, {4'd11, 4'd12});

      // zero operand: full run, weights unchanged
      @(negedge clk); x4 = {4'd0, 4'd5}; d4 = {4'd9, 4'd0}; dir4 = 2'b00; s4 = 1;
      run4(0, edges, bok);
      check("d4 zero latency", edges, L4 + 1);
      check("d4 zero result", wo4, {4'd11, 4'd12});

      // reset mid-RUN aborts, then a clean run from zero weights
      @(negedge clk); x4 = {4'd15, 4'd15}; d4 = {4'd15, 4'd15}; dir4 = 2'b00; s4 = 1;
      run4(2, edges, bok);
      @(negedge clk); rst = 1; s4 = 0;
      @(negedge clk); s4 = 1;
      run4(0, edges, bok);
      check("d4 post-rst latency", edges, L4 + 1);
      check("d4 post-rst busy", bok, 1);
      check("d4 post-rst result", wo4, {4'd14, 4'd14});

      // bit-reversed W=4: 8,8 gives 4 ones out of 16
      @(negedge clk); wlb = 1; wib = 4'd0; xb = 4'd8; db = 4'd8; dirb = 1'b0; sb = 1;
      runb(1, edges, bok);
      check("db latency", edges, LB + 1);
      check("db busy span", bok, 1);
      check("db add", wob, 4'd4);

      // 15,15 gives 15 ones: 3+15 clamps to 15
      @(negedge clk); wlb = 1; wib = 4'd3; xb = 4'd15; db = 4'd15; sb = 1;
      runb(0, edges, bok);
      check("db sat", wob, 4'd15);

      @(negedge clk); xb = 4'd8; db = 4'd8; dirb = 1'b1; sb = 1;
      runb(0, edges, bok);
      check("db sub", wob, 4'd11);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
